// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder family and the ALU flag register.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents: GROUP_W lookahead group width, num_groups() group count helper,
//           blk_gen() 4-bit block generate, cla_flags_t condition flag bundle.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // Block generate of a 4-bit group: carry leaves the group regardless of its carry-in.
    function automatic logic blk_gen(input logic [GROUP_W-1:0] p, input logic [GROUP_W-1:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } cla_flags_t;

endpackage

// File: rtl/cla_group4.sv
// First-level 4-bit carry lookahead: bit carries from a group carry-in, plus block P/G.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: p, g   per-bit propagate / generate of the group
//        ci     group carry-in
//        c      carry into each bit (c[0] = ci)
//        bp, bg block propagate / generate
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] c,
    output logic       bp,
    output logic       bg
);

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign bp = &p;
    assign bg = blk_gen(p, g);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with carry/overflow/zero/negative flags.
// Latency: result valid two edges after accept; sustains one beat per cycle.
// Backpressure: out_ready low stalls S2, then S1; in_ready follows out_ready combinationally.
//
// Ports: clk, rst (synchronous, active-high)
//        in_valid/in_ready with a, b, sub (0 add, 1 subtract), cin (carry-in / borrow-in)
//        out_valid/out_ready with sum, cout (subtract: 1 = no borrow), ovf, zero, neg
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N_GRP = num_groups(WIDTH);
    localparam int N_SG  = (N_GRP + 3) / 4;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
        $error("cla_addsub_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    // ---------------- handshake ----------------
    logic s1_vld;
    logic s2_adv;
    logic s1_adv;
    logic in_xfer;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = !rst && s1_adv;
    assign in_xfer  = in_valid && in_ready;

    // ---------------- stage 1: propagate / generate ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [N_GRP-1:0] bp_d;
    logic [N_GRP-1:0] bg_d;

    // Subtract is a + ~b + 1 with the borrow-in folded into the inverted carry-in.
    assign b_eff = sub ? ~b : b;
    assign p_d   = a ^ b_eff;
    assign g_d   = a & b_eff;

    always_comb begin
        bp_d = '0;
        bg_d = '0;
        for (int i = 0; i < N_GRP; i++) begin
            bp_d[i] = &p_d[i*GROUP_W +: GROUP_W];
            bg_d[i] = blk_gen(p_d[i*GROUP_W +: GROUP_W], g_d[i*GROUP_W +: GROUP_W]);
        end
    end

    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [N_GRP-1:0] s1_bp;
    logic [N_GRP-1:0] s1_bg;
    logic             s1_c0;

    // ---------------- stage 2: second-level lookahead ----------------
    // Block P/G padded to whole super-groups so lookahead reads stay in range.
    logic [N_SG*4-1:0] la_p;
    logic [N_SG*4-1:0] la_g;
    logic [N_GRP:0]    gc;   // carry into each group; gc[N_GRP] is the final carry-out

    always_comb begin
        la_p = '0;
        la_g = '0;
        la_p[N_GRP-1:0] = s1_bp;
        la_g[N_GRP-1:0] = s1_bg;
    end

    // Each group carry is a flat sum-of-products over the preceding groups of its
    // super-group (up to 4) and the super-group carry-in; super-groups ripple.
    always_comb begin
        logic c_acc;
        logic p_acc;
        c_acc = 1'b0;
        p_acc = 1'b1;
        gc    = '0;
        gc[0] = s1_c0;
        for (int gi = 1; gi <= N_GRP; gi++) begin
            c_acc = 1'b0;
            p_acc = 1'b1;
            for (int k = 3; k >= 0; k--) begin
                if (((gi - 1) / 4) * 4 + k < gi) begin
                    c_acc = c_acc | (p_acc & la_g[((gi - 1) / 4) * 4 + k]);
                    p_acc = p_acc & la_p[((gi - 1) / 4) * 4 + k];
                end
            end
            gc[gi] = c_acc | (p_acc & gc[((gi - 1) / 4) * 4]);
        end
    end

    logic [WIDTH-1:0] bit_c;
    logic [N_GRP-1:0] grp_bp;
    logic [N_GRP-1:0] grp_bg;
    logic             grp_pg_unused;

    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
        cla_group4 u_grp (
            .p  (s1_p[gi*GROUP_W +: GROUP_W]),
            .g  (s1_g[gi*GROUP_W +: GROUP_W]),
            .ci (gc[gi]),
            .c  (bit_c[gi*GROUP_W +: GROUP_W]),
            .bp (grp_bp[gi]),
            .bg (grp_bg[gi])
        );
    end

    // The lookahead uses the block P/G registered in S1 so group carries depend only
    // on flops; the instances' own P/G copies are not needed.
    assign grp_pg_unused = ^{grp_bp, grp_bg};

    logic [WIDTH-1:0] sum_d;
    cla_flags_t       flags_d;
    cla_flags_t       flags_q;

    always_comb begin
        flags_d      = '0;
        sum_d        = s1_p ^ bit_c;
        flags_d.cout = gc[N_GRP];
        flags_d.ovf  = bit_c[WIDTH-1] ^ gc[N_GRP];
        flags_d.zero = ~|sum_d;
        flags_d.neg  = sum_d[WIDTH-1];
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_bp     <= '0;
            s1_bg     <= '0;
            s1_c0     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            flags_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_vld <= in_xfer;
                if (in_xfer) begin
                    s1_p  <= p_d;
                    s1_g  <= g_d;
                    s1_bp <= bp_d;
                    s1_bg <= bg_d;
                    s1_c0 <= cin ^ sub;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_vld;
                // Data and flags only change when a beat actually moves into S2.
                if (s1_vld) begin
                    sum     <= sum_d;
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign cout = flags_q.cout;
    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;
    assign neg  = flags_q.neg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
    } beat_t;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } dvec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        sub;
    logic        cin;
    logic        out_ready;
    logic [63:0] a64;
    logic [63:0] b64;

    logic        ir32, ov32, co32, of32, z32, n32;
    logic [31:0] s32;
    logic        ir4, ov4, co4, of4, z4, n4;
    logic [3:0]  s4;
    logic        ir64, ov64, co64, of64, z64, n64;
    logic [63:0] s64;

    int n_checks = 0;
    int n_fail   = 0;

    cla_addsub_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a64[31:0]), .b(b64[31:0]), .sub(sub), .cin(cin),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32),
        .cout(co32), .ovf(of32), .zero(z32), .neg(n32)
    );

    cla_addsub_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .a(a64[3:0]), .b(b64[3:0]), .sub(sub), .cin(cin),
        .out_valid(ov4), .out_ready(out_ready), .sum(s4),
        .cout(co4), .ovf(of4), .zero(z4), .neg(n4)
    );

    cla_addsub_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64),
        .a(a64), .b(b64), .sub(sub), .cin(cin),
        .out_valid(ov64), .out_ready(out_ready), .sum(s64),
        .cout(co64), .ovf(of64), .zero(z64), .neg(n64)
    );

    // Reference: true integer add/subtract of w-bit operands, flags from the
    // unsigned and signed mathematical results.
    function automatic res_t ref_model(input int w, input beat_t bt);
        res_t               r;
        logic [67:0]        mask, ua, ub, ci, ures;
        logic signed [67:0] sa, sb, sres, smax;
        mask = (68'd1 << w) - 68'd1;
        ua   = {4'd0, bt.a} & mask;
        ub   = {4'd0, bt.b} & mask;
        ci   = {67'd0, bt.cin};
        sa   = ua[w-1] ? $signed(ua - mask - 68'd1) : $signed(ua);
        sb   = ub[w-1] ? $signed(ub - mask - 68'd1) : $signed(ub);
        if (!bt.sub) begin
            ures   = ua + ub + ci;
            r.cout = (ures > mask);
            sres   = sa + sb + $signed(ci);
        end else begin
            ures   = ua - ub - ci;
            r.cout = (ua >= ub + ci);
            sres   = sa - sb - $signed(ci);
        end
        smax   = $signed(mask >> 1);
        r.ovf  = (sres > smax) || (sres < -smax - 68'sd1);
        r.sum  = ures[63:0] & mask[63:0];
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[w-1];
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.a   = {$urandom, $urandom};
        bt.b   = {$urandom, $urandom};
        bt.sub = 1'($urandom_range(0, 1));
        bt.cin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: bt.b = ~bt.a;             // full propagate chain on add
            1: bt.b = bt.a;              // full propagate chain on subtract
            2: bt.a = ~64'd0;
            default: ;
        endcase
        return bt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t bt);
        a64 = bt.a;
        b64 = bt.b;
        sub = bt.sub;
        cin = bt.cin;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a64 = '0; b64 = '0; sub = 1'b0; cin = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ir32 !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", ir32);
        end
        n_checks++;
        if ({ov32, s32, co32, of32, z32, n32} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b sum=%h c=%b v=%b z=%b n=%b want all 0",
                     ov32, s32, co32, of32, z32, n32);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ir32 !== 1'b1) begin
            n_fail++; $display("FAIL in_ready_after_reset: got %b want 1", ir32);
        end
    endtask

    task automatic test_directed();
        dvec_t tbl [7];
        tbl[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h0000_0005, 32'h3, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0000, 32'h1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'h0FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            a64 = {32'd0, tbl[i].a};
            b64 = {32'd0, tbl[i].b};
            sub = tbl[i].sub;
            cin = tbl[i].cin;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (ir32 !== 1'b1) begin
                n_fail++; $display("FAIL directed_in_ready[%0d]: got %b want 1", i, ir32);
            end
            tick();
            in_valid = 1'b0;
            n_checks++;
            if (ov32 !== 1'b0) begin
                n_fail++; $display("FAIL directed_early_valid[%0d]: got %b want 0", i, ov32);
            end
            tick();
            n_checks++;
            if ({ov32, s32, co32, of32, z32, n32} !==
                {1'b1, tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].neg}) begin
                n_fail++;
                $display("FAIL directed[%0d]: valid=%b sum=%h c=%b v=%b z=%b n=%b want valid=1 sum=%h c=%b v=%b z=%b n=%b",
                         i, ov32, s32, co32, of32, z32, n32,
                         tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].neg);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t  exp_q [$];
        res_t  e;
        beat_t bt;
        for (int t = 0; t < 10; t++) begin
            out_ready = 1'b1;
            if (t < 8) begin
                bt = rand_beat();
                drive(bt);
                in_valid = 1'b1;
                exp_q.push_back(ref_model(32, bt));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) begin
                n_checks++;
                if (ir32 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, ir32);
                end
            end
            tick();
            if (t >= 1 && t <= 8) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({ov32, s32, co32, of32, z32, n32} !==
                    {1'b1, e.sum[31:0], e.cout, e.ovf, e.zero, e.neg}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: valid=%b sum=%h flags=%b want valid=1 sum=%h flags=%b",
                             t - 1, ov32, s32, {co32, of32, z32, n32},
                             e.sum[31:0], {e.cout, e.ovf, e.zero, e.neg});
                end
            end else begin
                n_checks++;
                if (ov32 !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_idle_valid[%0d]: got %b want 0", t, ov32);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t bts [4];
        res_t  e0, e;
        int    idx;
        int    got;
        logic  acc;
        for (int i = 0; i < 4; i++) bts[i] = rand_beat();
        e0  = ref_model(32, bts[0]);
        idx = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(bts[idx]);
            #1;
            acc = ir32 && in_valid;
            tick();
            if (acc) idx++;
            if (c >= 2) begin
                n_checks++;
                if ({ov32, s32, co32, of32, z32, n32} !==
                    {1'b1, e0.sum[31:0], e0.cout, e0.ovf, e0.zero, e0.neg}) begin
                    n_fail++;
                    $display("FAIL hold_stable[%0d]: valid=%b sum=%h want valid=1 sum=%h",
                             c, ov32, s32, e0.sum[31:0]);
                end
            end
        end
        drive(bts[idx]);
        #1;
        n_checks++;
        if (idx !== 2) begin
            n_fail++; $display("FAIL hold_accepted: got %0d want 2", idx);
        end
        n_checks++;
        if (ir32 !== 1'b0) begin
            n_fail++; $display("FAIL hold_in_ready: got %b want 0", ir32);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ov32 === 1'b1) begin
                e = ref_model(32, bts[(got < 2) ? got : 3]);
                n_checks++;
                if (got >= 2 || s32 !== e.sum[31:0] || {co32, of32, z32, n32} !== {e.cout, e.ovf, e.zero, e.neg}) begin
                    n_fail++;
                    $display("FAIL drain_result[%0d]: sum=%h want %h", got, s32, e.sum[31:0]);
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++; $display("FAIL drain_count: got %0d want 2", got);
        end
    endtask

    task automatic test_reset_flush();
        int seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(rand_beat());
        tick();
        drive(rand_beat());
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (ov32 !== 1'b1 || ir32 !== 1'b0) begin
            n_fail++; $display("FAIL flush_full: valid=%b in_ready=%b want 1 0", ov32, ir32);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ir32 !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready_rst: got %b want 0", ir32);
        end
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ov32, s32, co32, of32, z32, n32} !== 37'd0) begin
            n_fail++; $display("FAIL flush_outputs: valid=%b sum=%h want 0 0", ov32, s32);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ov32 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_ghost_beats: got %0d want 0", seen);
        end
    endtask

    task automatic test_random();
        localparam int N_BEATS = 10000;
        beat_t sb_q [$];
        beat_t cur;
        beat_t bt;
        res_t  e;
        logic  have_cur;
        logic  hold_prev;
        logic [35:0] prev32;
        int    sent;
        int    recv;
        int    cyc;
        have_cur  = 1'b0;
        hold_prev = 1'b0;
        prev32    = '0;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < N_BEATS && cyc < 60000) begin
            if (!have_cur) begin
                cur = rand_beat();
                have_cur = 1'b1;
            end
            drive(cur);
            in_valid  = (sent < N_BEATS) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_checks++;
            if (ir4 !== ir32 || ir64 !== ir32 || ov4 !== ov32 || ov64 !== ov32) begin
                n_fail++;
                $display("FAIL rand_handshake_align[%0d]: ir=%b%b%b ov=%b%b%b", cyc,
                         ir4, ir32, ir64, ov4, ov32, ov64);
            end
            if (hold_prev) begin
                n_checks++;
                if (ov32 !== 1'b1 || {s32, co32, of32, z32, n32} !== prev32) begin
                    n_fail++;
                    $display("FAIL rand_hold_stable[%0d]: valid=%b data=%h want 1 %h",
                             cyc, ov32, {s32, co32, of32, z32, n32}, prev32);
                end
            end
            if (ov32 === 1'b1 && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_unexpected_output[%0d]: sum=%h", cyc, s32);
                end else begin
                    bt = sb_q.pop_front();
                    e = ref_model(32, bt);
                    n_checks++;
                    if ({s32, co32, of32, z32, n32} !== {e.sum[31:0], e.cout, e.ovf, e.zero, e.neg}) begin
                        n_fail++;
                        $display("FAIL rand_w32[%0d]: a=%h b=%h sub=%b cin=%b got %h/%b want %h/%b",
                                 recv, bt.a[31:0], bt.b[31:0], bt.sub, bt.cin, s32,
                                 {co32, of32, z32, n32}, e.sum[31:0], {e.cout, e.ovf, e.zero, e.neg});
                    end
                    e = ref_model(4, bt);
                    n_checks++;
                    if ({s4, co4, of4, z4, n4} !== {e.sum[3:0], e.cout, e.ovf, e.zero, e.neg}) begin
                        n_fail++;
                        $display("FAIL rand_w4[%0d]: a=%h b=%h sub=%b cin=%b got %h/%b want %h/%b",
                                 recv, bt.a[3:0], bt.b[3:0], bt.sub, bt.cin, s4,
                                 {co4, of4, z4, n4}, e.sum[3:0], {e.cout, e.ovf, e.zero, e.neg});
                    end
                    e = ref_model(64, bt);
                    n_checks++;
                    if ({s64, co64, of64, z64, n64} !== {e.sum, e.cout, e.ovf, e.zero, e.neg}) begin
                        n_fail++;
                        $display("FAIL rand_w64[%0d]: a=%h b=%h sub=%b cin=%b got %h/%b want %h/%b",
                                 recv, bt.a, bt.b, bt.sub, bt.cin, s64,
                                 {co64, of64, z64, n64}, e.sum, {e.cout, e.ovf, e.zero, e.neg});
                    end
                end
                recv++;
            end
            hold_prev = (ov32 === 1'b1) && !out_ready;
            prev32    = {s32, co32, of32, z32, n32};
            if (in_valid && ir32 === 1'b1) begin
                sb_q.push_back(cur);
                sent++;
                have_cur = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv < N_BEATS) begin
            n_fail++;
            $display("FAIL rand_timeout: received %0d want %0d", recv, N_BEATS);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
# cla_addsub_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. It carries the 4-bit group lookahead scheme to arbitrary widths with a second lookahead level across groups. It adds subtract and subtract-with-borrow modes and produces carry, overflow, zero and negative flags. It sits in the RISC datapath between operand fetch and writeback, and can be reused for address arithmetic.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4 and at least 4.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in for add; borrow-in for subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer takes the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - Add computes a + b + cin.
  - Subtract computes a − b − cin (two's complement, SBC semantics).
- Stage 1 (S1), registered on accept:
  - Per-bit p = a ^ b_eff and g = a & b_eff.
  - Per-4-bit-group block P and G.
  - Registers c0, and holds p and g.
- Stage 2 (S2), registered into the output:
  - Group carries are computed by second-level lookahead over up to 4 groups per super-group; super-groups ripple.
  - Within each group, bit carries come from 4-bit lookahead using the group's carry-in.
  - sum = p ^ c.
  - cout = carry out of bit WIDTH-1.
  - ovf = c[WIDTH-1] ^ cout.
  - zero = ~|sum.
  - neg = sum[WIDTH-1].
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - S2 advances when it is empty or out_ready = 1.
  - S1 advances when it is empty or S2 advances.
  - in_ready = !rst && (S1 empty || S2 advances). in_ready depends combinationally on out_ready.
- Outputs hold stable while out_valid && !out_ready. Data and flags change only on a transfer or on reset.

## Timing
- Reset state: out_valid = 0, sum = 0, cout = ovf = zero = neg = 0. Both stages are empty.
- in_ready is 0 while rst = 1 and 1 in the first cycle after reset.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+1, i.e. two edges.
- Throughput: one beat per cycle while out_ready = 1.
- Full pipeline (both stages valid) with out_ready = 0: in_ready = 0, nothing moves.
- Full pipeline with out_ready = 1 and in_valid = 1: the output drains, S1 moves to S2, and the new beat enters S1 on the same edge. No bubble.
- Reset asserted mid-operation: both stages are flushed on that edge. In-flight beats are discarded and never presented.
- WIDTH = 4: a single group; the second level degenerates to a pass-through of the group carry.
- WIDTH % 4 != 0 or WIDTH < 4: elaboration-time error.

## Structure
- Shared package `cla_pkg`:
  - Constant GROUP_W = 4.
  - Function for the number of groups (WIDTH/GROUP_W).
  - Packed struct `cla_flags_t` {cout, ovf, zero, neg}, also reused by the ALU flag register.
- Sub-module `cla_group4`:
  - Purely combinational.
  - Inputs: 4-bit p and g vectors, and the group carry-in.
  - Outputs: 4 bit carries and block P/G.
  - Instantiated WIDTH/4 times.
- The top level holds the two pipeline registers, the handshake logic and the second-level lookahead.

## Test plan
- WIDTH=32, add a=0xFFFF_FFFF, b=1, cin=0 → sum=0, cout=1, ovf=0, zero=1, neg=0, two edges after accept.
- Add a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, ovf=1, neg=1, cout=0. Subtract a=5, b=3, cin=0 → sum=2, cout=1.
- Subtract a=0, b=1, cin=1 → sum=0xFFFF_FFFE, cout=0 (borrow), neg=1. Carry chain across every group boundary: a=0x0FFF_FFFF, b=1 → 0x1000_0000.
- Back-to-back stream of 8 beats with out_ready held at 1 → 8 results in order on 8 consecutive cycles, in_ready held at 1.
- Hold out_ready=0 for 5 cycles with in_valid=1 → exactly 2 beats accepted, in_ready=0 afterwards, output stable. Then release → remaining beats drain in order with no loss or duplication.
- Assert rst for one cycle with both stages full → out_valid=0 on the next cycle, flushed beats never appear. Also run WIDTH=4 and WIDTH=64 builds against a random reference-model comparison (≥10k beats, random out_ready).
